// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Ports: clk, reset (async, active-low), A/B operands, MdOp, Start, Req
//        in; Busy (op in flight), HI, LO out.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MdOp,
    input  logic        Start,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   tmp_hi, tmp_lo;
    logic          dz;

    logic          is_mul, is_div, is_sgn;
    logic          go, done, wr_hi, wr_lo;

    assign is_mul = (MdOp == 3'd1) || (MdOp == 3'd2);
    assign is_div = (MdOp == 3'd3) || (MdOp == 3'd4);
    assign is_sgn = (MdOp == 3'd1) || (MdOp == 3'd3);

    assign go    = (state == IDLE) && Start && !Req && (is_mul || is_div);
    assign done  = (state == RUN) && (cnt == CW'(1));
    assign wr_hi = (state == IDLE) && !Req && (MdOp == 3'd5);
    assign wr_lo = (state == IDLE) && !Req && (MdOp == 3'd6);

    // Multiply: both operands widened to 64 bits so one multiplier
    // shape serves signed and unsigned.
    logic [63:0] mul_a, mul_b, prod;

    assign mul_a = is_sgn ? {{32{A[31]}}, A} : {32'd0, A};
    assign mul_b = is_sgn ? {{32{B[31]}}, B} : {32'd0, B};
    assign prod  = mul_a * mul_b;

    // Divide on magnitudes, then restore signs. This also makes
    // 0x80000000 / -1 wrap to 0x80000000 with zero remainder.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, dvsr;
    logic [31:0] q_mag, r_mag, quo, rem;

    assign a_neg = is_sgn && A[31];
    assign b_neg = is_sgn && B[31];
    assign a_mag = a_neg ? (~A + 32'd1) : A;
    assign b_mag = b_neg ? (~B + 32'd1) : B;
    // Divide by zero never commits; avoid a zero divisor in the logic.
    assign dvsr  = (B == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / dvsr;
    assign r_mag = a_mag % dvsr;
    assign quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (go)   state_n = RUN;
            RUN:     if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state == RUN);
    end

    // Counter and operation result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
            dz     <= 1'b0;
        end else if (go) begin
            cnt    <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            tmp_hi <= is_mul ? prod[63:32] : rem;
            tmp_lo <= is_mul ? prod[31:0]  : quo;
            dz     <= is_div && (B == 32'd0);
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (done) begin
            if (!dz) begin
                HI <= tmp_hi;
                LO <= tmp_lo;
            end
        end else begin
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;
        end
    end

endmodule
